// File: rtl/tap_shift_buffer.sv
// Tap shift buffer: a DEPTH-deep, WIDTH-wide sample delay line, updated on the falling clock edge.
// Optional synchronous clear input `clr` is present when TAP_SHIFT_CLEAR_EN is defined.
module tap_shift_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int MODE  = 0
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         ena,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             data,
    input  logic                         win_ack,
`ifdef TAP_SHIFT_CLEAR_EN
    input  logic                         clr,
`endif
    output logic [WIDTH*DEPTH-1:0]       taps,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         win_valid,
    output logic                         o_dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_tap [DEPTH];
    logic [CW-1:0]     r_count;
    logic              r_win_valid;

    logic              w_accept;
    logic              w_ack;
    logic              w_clr;
    logic [CW-1:0]     w_count_inc;

`ifdef TAP_SHIFT_CLEAR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    // Handshake: a sample transfers on a falling edge where ena, in_valid and
    // in_ready are all high. in_ready depends only on ena and state, never on in_valid.
    assign in_ready    = (MODE == 0) ? ena : (ena && (r_state == FILL));
    assign w_accept    = ena && in_valid && in_ready;
    assign w_ack       = (MODE == 1) && ena && win_ack && (r_state == HOLD);
    assign w_count_inc = (r_count == FULL) ? FULL : (r_count + CW'(1));

    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_tap[k] <= '0;
            end
            r_count     <= '0;
            r_win_valid <= 1'b0;
            r_state     <= FILL;
        end else if (w_clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_tap[k] <= '0;
            end
            r_count     <= '0;
            r_win_valid <= 1'b0;
            r_state     <= FILL;
        end else if (w_accept) begin
            r_tap[0] <= data;
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_tap[k] <= r_tap[k-1];
            end
            r_count     <= w_count_inc;
            r_win_valid <= (w_count_inc == FULL);
            if ((MODE == 1) && (w_count_inc == FULL)) begin
                r_state <= HOLD;
            end
        end else if (w_ack) begin
            // Releasing the window restarts the count; tap contents stay put.
            r_count     <= '0;
            r_win_valid <= 1'b0;
            r_state     <= FILL;
        end
    end

    always_comb begin
        taps = '0;
        for (int k = 0; k < DEPTH; k++) begin
            taps[k*WIDTH +: WIDTH] = r_tap[k];
        end
    end

    assign count       = r_count;
    assign win_valid   = r_win_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_tap_shift_buffer.sv
// Bench for tap_shift_buffer: a sliding instance (MODE=0, DEPTH=16) and a block instance
// (MODE=1, DEPTH=4) checked against a history-queue reference model.
module tb_tap_shift_buffer;

  localparam int W  = 16;
  localparam int D0 = 16;
  localparam int D1 = 4;

  logic clk = 1'b0;
  logic rstb = 1'b0;

  logic ena0 = 1'b0, valid0 = 1'b0, ack0 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic rdy0, wv0, st0;
  logic [W*D0-1:0] taps0;
  logic [$clog2(D0+1)-1:0] cnt0;

  logic ena1 = 1'b0, valid1 = 1'b0, ack1 = 1'b0;
  logic [W-1:0] data1 = '0;
  logic rdy1, wv1, st1;
  logic [W*D1-1:0] taps1;
  logic [$clog2(D1+1)-1:0] cnt1;

`ifdef TAP_SHIFT_CLEAR_EN
  logic clr0 = 1'b0, clr1 = 1'b0;
`endif

  // newest sample at index 0; tap contents beyond the history are zero
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int m_cnt0 = 0;
  int m_cnt1 = 0;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tap_shift_buffer #(.WIDTH(W), .DEPTH(D0), .MODE(0)) dut0 (
    .clk(clk), .rstb(rstb), .ena(ena0), .in_valid(valid0), .in_ready(rdy0),
    .data(data0), .win_ack(ack0),
`ifdef TAP_SHIFT_CLEAR_EN
    .clr(clr0),
`endif
    .taps(taps0), .count(cnt0), .win_valid(wv0), .o_dbg_state(st0)
  );

  tap_shift_buffer #(.WIDTH(W), .DEPTH(D1), .MODE(1)) dut1 (
    .clk(clk), .rstb(rstb), .ena(ena1), .in_valid(valid1), .in_ready(rdy1),
    .data(data1), .win_ack(ack1),
`ifdef TAP_SHIFT_CLEAR_EN
    .clr(clr1),
`endif
    .taps(taps1), .count(cnt1), .win_valid(wv1), .o_dbg_state(st1)
  );

  // ---------------- reference model ----------------
  function automatic logic [255:0] exp_taps0();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < D0 && k < exp_q0.size(); k++) v[k*W +: W] = exp_q0[k];
    return v;
  endfunction

  function automatic logic [255:0] exp_taps1();
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < D1 && k < exp_q1.size(); k++) v[k*W +: W] = exp_q1[k];
    return v;
  endfunction

  function automatic logic [255:0] exp_tap0_k(input int k);
    return (k < exp_q0.size()) ? 256'(exp_q0[k]) : 256'(0);
  endfunction

  function automatic void model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all0(input string tag);
    check({tag, "_taps0"}, taps0, exp_taps0());
    check({tag, "_cnt0"}, cnt0, m_cnt0);
    check({tag, "_wv0"}, wv0, (m_cnt0 == D0) ? 1 : 0);
  endtask

  task automatic check_all1(input string tag);
    check({tag, "_taps1"}, taps1, exp_taps1());
    check({tag, "_cnt1"}, cnt1, m_cnt1);
    check({tag, "_wv1"}, wv1, (m_cnt1 == D1) ? 1 : 0);
    check({tag, "_st1"}, st1, (m_cnt1 == D1) ? 1 : 0);
  endtask

  // ---------------- drivers ----------------
  task automatic step0(input logic e, input logic v, input logic [W-1:0] d);
    bit acc;
    ena0 = e; valid0 = v; data0 = d; ack0 = 1'($urandom_range(0, 1));
    ena1 = 1'b0; valid1 = 1'b0; ack1 = 1'b0;
    #1;
    check("rdy0_pre", rdy0, e);
    acc = e && v;
    if (acc) begin
      exp_q0.push_front(d);
      if (exp_q0.size() > D0) void'(exp_q0.pop_back());
      if (m_cnt0 < D0) m_cnt0++;
    end
    @(negedge clk);
    #1;
    check_all0("s0");
  endtask

  task automatic step1(input logic e, input logic v, input logic a, input logic [W-1:0] d);
    bit hold, rdy, acc;
    ena1 = e; valid1 = v; data1 = d; ack1 = a;
    ena0 = 1'b0; valid0 = 1'b0; ack0 = 1'b0;
    #1;
    hold = (m_cnt1 == D1);
    rdy = e && !hold;
    check("rdy1_pre", rdy1, rdy);
    acc = e && v && rdy;
    if (acc) begin
      exp_q1.push_front(d);
      if (exp_q1.size() > D1) void'(exp_q1.pop_back());
      m_cnt1++;
    end else if (e && a && hold) begin
      m_cnt1 = 0;
    end
    @(negedge clk);
    #1;
    check_all1("s1");
    check("rdy1_post", rdy1, e && (m_cnt1 != D1));
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    ena0 = 1'b0; valid0 = 1'b0; ena1 = 1'b0; valid1 = 1'b0; ack1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    @(posedge clk);
    rstb = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    do_reset();
    #1;
    check_all0("reset");
    check_all1("reset");
    check("reset_rdy0", rdy0, 0);

    // fill sliding window with 1..16
    for (int i = 1; i <= 16; i++) step0(1'b1, 1'b1, W'(i));
    check("fill_tap0", taps0[0 +: W], 16'h0010);
    check("fill_tap15", taps0[15*W +: W], 16'h0001);
    check("fill_cnt", cnt0, 16);
    check("fill_wv", wv0, 1);

    step0(1'b1, 1'b1, 16'h0011);
    check("slide_tap0", taps0[0 +: W], 16'h0011);
    check("slide_tap15", taps0[15*W +: W], 16'h0002);
    check("slide_cnt", cnt0, 16);
    check("slide_rdy", rdy0, 1);

    // enable freeze
    for (int i = 0; i < 5; i++) step0(1'b0, 1'b1, W'($urandom_range(0, 16'hFFFF)));
    check("ena_tap0", taps0[0 +: W], 16'h0011);

    // block window
    step1(1'b1, 1'b1, 1'b0, 16'h000A);
    step1(1'b1, 1'b1, 1'b0, 16'h000B);
    step1(1'b1, 1'b1, 1'b0, 16'h000C);
    step1(1'b1, 1'b1, 1'b0, 16'h000D);
    check("blk_rdy_after_d", rdy1, 0);
    step1(1'b1, 1'b1, 1'b0, 16'h000E);
    check("blk_taps", taps1, 64'h000A_000B_000C_000D);
    // ack and valid together: no shift, count clears
    step1(1'b1, 1'b1, 1'b1, 16'h000F);
    check("race_cnt", cnt1, 0);
    check("race_st", st1, 0);
    check("race_taps", taps1, 64'h000A_000B_000C_000D);
    check("race_rdy", rdy1, 1);
    // ack during fill does nothing
    step1(1'b1, 1'b0, 1'b1, 16'h0000);
    check("fill_ack_cnt", cnt1, 0);

    // asynchronous reset mid-fill
    do_reset();
    for (int i = 1; i <= 3; i++) step0(1'b1, 1'b1, W'(16'h0100 + i));
    check("pre_rst_cnt", cnt0, 3);
    #2 rstb = 1'b0;
    #1;
    check("arst_taps0", taps0, 0);
    check("arst_cnt0", cnt0, 0);
    check("arst_wv0", wv0, 0);
    model_reset();
    @(posedge clk);
    rstb = 1'b1;
    step0(1'b1, 1'b1, 16'h1234);
    check("first_acc_cnt", cnt0, 1);
    check("first_acc_tap0", taps0[0 +: W], 16'h1234);

`ifdef TAP_SHIFT_CLEAR_EN
    step0(1'b1, 1'b1, 16'h4321);
    ena0 = 1'b0; valid0 = 1'b1; clr0 = 1'b1;
    @(negedge clk);
    #1;
    clr0 = 1'b0;
    exp_q0.delete();
    m_cnt0 = 0;
    check("clr_taps0", taps0, 0);
    check("clr_cnt0", cnt0, 0);
`endif

    // random sliding traffic
    for (int i = 0; i < 60; i++)
      step0(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), W'($urandom_range(0, 16'hFFFF)));
    for (int k = 0; k < D0; k++) check("rnd_tapk", taps0[k*W +: W], exp_tap0_k(k));

    // random block traffic
    for (int i = 0; i < 80; i++)
      step1(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), W'($urandom_range(0, 16'hFFFF)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tap_shift_buffer.md
TAP_SHIFT_BUFFER -- requirements
Module: tap_shift_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the sole clock and rstb is the reset.
REQ-002 Parameter WIDTH SHALL default to 16: bits per sample; legal range 1..64.
REQ-003 Parameter DEPTH SHALL default to 16: number of taps; legal range 2..256.
REQ-004 Parameter MODE SHALL default to 0: 0 = sliding window, 1 = block window.
REQ-005 Port clk SHALL be an input, 1 bit: clock; all state updates on its falling edge.
REQ-006 Port rstb SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-007 Port ena SHALL be an input, 1 bit: global enable; low freezes all state.
REQ-008 Port in_valid SHALL be an input, 1 bit: data holds a sample.
REQ-009 Port in_ready SHALL be an output, 1 bit: the block can accept a sample this cycle.
REQ-010 Port data SHALL be an input, WIDTH bits: sample in.
REQ-011 Port win_ack SHALL be an input, 1 bit: the consumer releases a held window (MODE=1 only; ignored when MODE=0).
REQ-012 Port taps SHALL be an output, WIDTH*DEPTH bits: tap k occupies [k*WIDTH +: WIDTH]; tap 0 is the newest sample.
REQ-013 Port count SHALL be an output, $clog2(DEPTH+1) bits: number of samples accepted since the last reset, ack or clear, saturating at DEPTH.
REQ-014 Port win_valid SHALL be an output, 1 bit: high when count equals DEPTH.

Function
REQ-015 A sample SHALL be accepted on a falling edge only when ena, in_valid and in_ready are all high.
REQ-016 On acceptance, tap 0 SHALL load data and tap k SHALL load tap k-1 for k = 1..DEPTH-1; tap DEPTH-1 is discarded.
REQ-017 When ena is low, in_ready SHALL be low and taps, count and the FSM state SHALL hold.
REQ-018 in_ready SHALL be combinational from ena and the FSM state only, never from in_valid.
REQ-019 When MODE=0, in_ready SHALL equal ena, and count SHALL increment on each acceptance up to DEPTH, then remain at DEPTH.
REQ-020 When MODE=1, the FSM SHALL have two states, FILL and HOLD, and in_ready SHALL be ena AND (state==FILL).
REQ-021 FILL to HOLD SHALL occur on the acceptance that brings count to DEPTH.
REQ-022 HOLD to FILL SHALL occur on a falling edge with ena and win_ack high; count SHALL clear to 0 and taps SHALL retain their contents.
REQ-023 In HOLD, in_valid SHALL be ignored; a simultaneous win_ack and in_valid SHALL accept no sample, and in_ready rises in the following cycle.
REQ-024 In FILL, win_ack SHALL have no effect.
REQ-025 taps, count and win_valid SHALL be registered outputs, so a new value is visible immediately after the falling edge that updates it.

Reset
REQ-026 While rstb is low, all taps SHALL be 0, count SHALL be 0, win_valid SHALL be 0 and the FSM SHALL be in FILL, independent of clk.
REQ-027 A reset asserted mid-fill or mid-hold SHALL abandon the window; no partial state SHALL survive.
REQ-028 The first acceptance after rstb deasserts SHALL be possible on the first falling edge at which ena and in_valid are high.

Configuration
REQ-029 Macro TAP_SHIFT_CLEAR_EN, when defined, SHALL add an input clr (1 bit, synchronous).
REQ-030 When clr is high on a falling edge, all taps and count SHALL go to 0 and the FSM SHALL go to FILL; clr SHALL override ena, acceptance and win_ack.
REQ-031 When TAP_SHIFT_CLEAR_EN is undefined, the clr port and its logic SHALL be absent, and the only return to the all-zero state SHALL be rstb.

Verification
REQ-032 Reset/shift check: MODE=0, WIDTH=16, DEPTH=16; push 0x0001..0x0010 -> taps[15:0]=0x0010, tap 15=0x0001, count=16, win_valid=1.
REQ-033 Sliding check: continue with 0x0011 -> tap 0=0x0011, tap 15=0x0002, count stays 16, in_ready stays 1.
REQ-034 Block hold check: MODE=1, DEPTH=4; push 0xA,0xB,0xC,0xD then 0xE -> in_ready=0 after 0xD, 0xE not accepted, taps hold 0xD,0xC,0xB,0xA.
REQ-035 Ack race check: MODE=1 in HOLD; assert win_ack and in_valid together -> count=0, state FILL, no shift, in_ready=1 next cycle.
REQ-036 Enable check: ena=0 with in_valid=1 for 5 cycles -> in_ready=0; taps and count unchanged.
REQ-037 Async reset check: rstb low between edges at count=3 -> all outputs 0 before the next falling edge; with TAP_SHIFT_CLEAR_EN defined, clr=1 together with ena=0 -> taps and count are 0.
